ycbcr422_to_rgb565: RTL and testbench
=====================================

// Module: ycbcr422_to_rgb565
// PURPOSE
//  Converts an 8-bit YCbCr 4:2:2 pixel stream (Y plus interleaved Cb/Cr) back to RGB565 for display/overlay.
//  Sits after the chroma-domain processing stages and before the HDMI/LCD output path.
//  Fixed 5-cycle pipeline; vsync/href/de are delayed to match.
// PARAMETERS
//  CB_FIRST   1   1: chroma order Cb on even pixel, Cr on odd; 0: Cr first
//  COEF_FRAC  8   fractional bits of fixed-point coefficients (only 8 is supported)
// PORTS
//  clk               in   1  pixel clock; sole clock
//  rst               in   1  asynchronous, active-high reset
//  pre_frame_vsync   in   1  input vsync
//  pre_frame_href    in   1  input href
//  pre_frame_de      in   1  input data enable; a pixel is valid when high
//  img_y             in   8  luma
//  img_c             in   8  interleaved chroma (Cb/Cr per CB_FIRST)
//  post_frame_vsync  out  1  vsync delayed 5 cycles
//  post_frame_href   out  1  href delayed 5 cycles
//  post_frame_de     out  1  de delayed 5 cycles
//  img_red           out  5  R[7:3]; 0 when post_frame_de low
//  img_green         out  6  G[7:2]; 0 when post_frame_de low
//  img_blue          out  5  B[7:3]; 0 when post_frame_de low
// BEHAVIOUR
//  Reset: all pipeline registers, phase bit and chroma holds cleared; all outputs 0.
//  Phase: toggles on each de=1 cycle; forced to 0 while de=0 and while vsync asserted.
//  Chroma pairing: phase0 pixel latches first chroma into c_hold; on the phase1 pixel, pair_reg <= {c_hold, img_c}.
//   Y delayed 2 cycles, so both pixels of a pair see the same pair_reg.
//  Odd-length line: if de drops while phase=1, pair_reg <= {c_hold, 8'd128} (neutral second chroma).
//  Full range (default), d = C-128 (signed 9b), sums signed 20b:
//   R=(256Y+359dCr+128)>>>8  G=(256Y-88dCb-183dCr+128)>>>8  B=(256Y+454dCb+128)>>>8
//  Stages: S1-S2 pairing/Y delay; S3 registered products; S4 registered sums;
//   S5 clamp to 0..255 (neg->0, >255->255), pack RGB565, gate with de.
//  Latency: input pixel at cycle t appears at cycle t+5; throughput 1 pixel/clk, no stalls.
//  Back-to-back lines/frames: no gap required; phase restarts at first de of each line.
//  Reset mid-line: pipeline flushes to 0; first post-reset pixel is treated as phase0.
// CONFIGURATION
//  YCBCR2RGB_LIMITED_RANGE_EN defined: BT.601 studio range, Yl=Y-16 (signed);
//   R=(298Yl+409dCr+128)>>>8  G=(298Yl-100dCb-208dCr+128)>>>8  B=(298Yl+516dCb+128)>>>8;
//   same clamp and same 5-cycle latency.
//  Undefined: full-range coefficients above.
// STRUCTURE
//  Package ycbcr_pkg: coefficient localparams (both ranges), PIPE_LAT=5, CHROMA_OFFSET=128, LUMA_OFFSET=16.
//  Sub-module sync_delay (DEPTH=PIPE_LAT, WIDTH=3) carries vsync/href/de; all arithmetic stays in this module.
// TESTING
//  Reset: assert rst mid-frame -> all outputs 0 same cycle; after release the first pixel is treated as phase0.
//  Grey: Y=128,Cb=Cr=128 full range -> R/G/B=128 -> red=16, green=32, blue=16, exactly 5 cycles after input.
//  Saturate: Y=255,Cr=255,Cb=128 -> R clamps 255 (red=31); Y=0,Cb=0 -> B clamps 0 (blue=0), no wrap.
//  Pairing: line Y0=50,Cb=200,Y1=50,Cr=128 -> both output pixels equal (blue high, red=grey); swap CB_FIRST=0 -> red high instead.
//  Odd line: 3-pixel line, last Cb=200 -> third pixel uses Cr=128; next line restarts at phase0.
//  Limited (macro on): Y=16,Cb=Cr=128 -> 0/0/0; Y=235 -> red=31, green=63, blue=31.

Source files
------------

// File: rtl/ycbcr422_to_rgb565_pkg.sv
// Shared constants, types and saturation helpers for the YCbCr 4:2:2 -> RGB565 converter.
package ycbcr_pkg;

    localparam int         PIPE_LAT      = 5;
    localparam logic [7:0] CHROMA_OFFSET = 8'd128;
    localparam logic [7:0] LUMA_OFFSET   = 8'd16;

    localparam int SUM_W = 20;
    typedef logic signed [SUM_W-1:0] sum_t;

    // Full-range coefficients, Q8 fixed point; green terms are subtracted.
    localparam sum_t K_Y_FULL   = 20'sd256;
    localparam sum_t K_RCR_FULL = 20'sd359;
    localparam sum_t K_GCB_FULL = 20'sd88;
    localparam sum_t K_GCR_FULL = 20'sd183;
    localparam sum_t K_BCB_FULL = 20'sd454;

    // BT.601 studio-range coefficients, Q8 fixed point.
    localparam sum_t K_Y_LIM    = 20'sd298;
    localparam sum_t K_RCR_LIM  = 20'sd409;
    localparam sum_t K_GCB_LIM  = 20'sd100;
    localparam sum_t K_GCR_LIM  = 20'sd208;
    localparam sum_t K_BCB_LIM  = 20'sd516;

    typedef struct packed {
        logic [7:0] first;
        logic [7:0] second;
    } chroma_pair_t;

    typedef struct packed {
        sum_t y;
        sum_t r_cr;
        sum_t g_cb;
        sum_t g_cr;
        sum_t b_cb;
    } prod_t;

    // Inputs are already scaled so the 8-bit 0..255 range maps onto the field width.
    function automatic logic [4:0] clamp5(input sum_t v);
        if (v[SUM_W-1])
            return 5'd0;
        else if (|v[SUM_W-2:5])
            return 5'h1F;
        else
            return v[4:0];
    endfunction

    function automatic logic [5:0] clamp6(input sum_t v);
        if (v[SUM_W-1])
            return 6'd0;
        else if (|v[SUM_W-2:6])
            return 6'h3F;
        else
            return v[5:0];
    endfunction

endpackage

// File: rtl/ycbcr422_to_rgb565_sync_delay.sv
// Fixed-depth shift register for the frame sync strobes.
// Latency DEPTH cycles; no backpressure, advances every clock.
module sync_delay #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ycbcr422_to_rgb565.sv
// YCbCr 4:2:2 to RGB565; YCBCR2RGB_LIMITED_RANGE_EN selects BT.601 studio range.
// Latency 5 cycles (pair/Y delay x2, products, sums, clamp/pack), syncs matched.
// No backpressure: one pixel per clock, never stalls.
module ycbcr422_to_rgb565
    import ycbcr_pkg::*;
#(
    parameter int CB_FIRST  = 1,
    parameter int COEF_FRAC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_href,
    input  logic       pre_frame_de,
    input  logic [7:0] img_y,
    input  logic [7:0] img_c,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_de,
    output logic [4:0] img_red,
    output logic [5:0] img_green,
    output logic [4:0] img_blue
);

`ifdef YCBCR2RGB_LIMITED_RANGE_EN
    localparam bit LIMITED = 1'b1;
`else
    localparam bit LIMITED = 1'b0;
`endif

    localparam sum_t       K_Y      = LIMITED ? K_Y_LIM   : K_Y_FULL;
    localparam sum_t       K_RCR    = LIMITED ? K_RCR_LIM : K_RCR_FULL;
    localparam sum_t       K_GCB    = LIMITED ? K_GCB_LIM : K_GCB_FULL;
    localparam sum_t       K_GCR    = LIMITED ? K_GCR_LIM : K_GCR_FULL;
    localparam sum_t       K_BCB    = LIMITED ? K_BCB_LIM : K_BCB_FULL;
    localparam logic [7:0] Y_OFFSET = LIMITED ? LUMA_OFFSET : 8'd0;
    localparam sum_t       ROUND    = sum_t'(1 << (COEF_FRAC - 1));

    logic         phase;
    logic [7:0]   c_hold;
    logic [7:0]   y_d1;
    logic [7:0]   y_d2;
    chroma_pair_t pair;

    // Pair register updates one cycle after the phase1 pixel, so both pixels
    // of the pair reach the multipliers (Y delayed twice) with the same chroma.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= 1'b0;
            c_hold <= '0;
            y_d1   <= '0;
            y_d2   <= '0;
            pair   <= '0;
        end else begin
            y_d1  <= img_y;
            y_d2  <= y_d1;
            phase <= (pre_frame_de && !pre_frame_vsync) ? ~phase : 1'b0;
            if (pre_frame_de && !phase)
                c_hold <= img_c;
            if (phase) begin
                pair.first  <= c_hold;
                pair.second <= pre_frame_de ? img_c : CHROMA_OFFSET;
            end
        end
    end

    logic [7:0] cb_raw;
    logic [7:0] cr_raw;
    sum_t       d_cb;
    sum_t       d_cr;
    sum_t       y_s;

    assign cb_raw = (CB_FIRST != 0) ? pair.first  : pair.second;
    assign cr_raw = (CB_FIRST != 0) ? pair.second : pair.first;
    assign d_cb   = {12'd0, cb_raw} - {12'd0, CHROMA_OFFSET};
    assign d_cr   = {12'd0, cr_raw} - {12'd0, CHROMA_OFFSET};
    assign y_s    = {12'd0, y_d2}   - {12'd0, Y_OFFSET};

    prod_t prod_q;
    sum_t  r_sum;
    sum_t  g_sum;
    sum_t  b_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            r_sum  <= '0;
            g_sum  <= '0;
            b_sum  <= '0;
        end else begin
            prod_q.y    <= K_Y   * y_s;
            prod_q.r_cr <= K_RCR * d_cr;
            prod_q.g_cb <= K_GCB * d_cb;
            prod_q.g_cr <= K_GCR * d_cr;
            prod_q.b_cb <= K_BCB * d_cb;
            r_sum <= prod_q.y + prod_q.r_cr + ROUND;
            g_sum <= prod_q.y - prod_q.g_cb - prod_q.g_cr + ROUND;
            b_sum <= prod_q.y + prod_q.b_cb + ROUND;
        end
    end

    // Dropping the fraction and the unused low colour bits in one arithmetic
    // shift is equivalent to clamping to 8 bits and then truncating.
    sum_t r_sh;
    sum_t g_sh;
    sum_t b_sh;

    assign r_sh = r_sum >>> (COEF_FRAC + 3);
    assign g_sh = g_sum >>> (COEF_FRAC + 2);
    assign b_sh = b_sum >>> (COEF_FRAC + 3);

    logic [4:0] red_q;
    logic [5:0] green_q;
    logic [4:0] blue_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            red_q   <= clamp5(r_sh);
            green_q <= clamp6(g_sh);
            blue_q  <= clamp5(b_sh);
        end
    end

    logic [2:0] sync_q;

    sync_delay #(
        .DEPTH (PIPE_LAT),
        .WIDTH (3)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({pre_frame_vsync, pre_frame_href, pre_frame_de}),
        .dout (sync_q)
    );

    assign post_frame_vsync = sync_q[2];
    assign post_frame_href  = sync_q[1];
    assign post_frame_de    = sync_q[0];

    assign img_red   = post_frame_de ? red_q   : 5'd0;
    assign img_green = post_frame_de ? green_q : 6'd0;
    assign img_blue  = post_frame_de ? blue_q  : 5'd0;

endmodule

// File: tb/tb_ycbcr422_to_rgb565.sv
// Bench for ycbcr422_to_rgb565: Cb-first and Cr-first instances share one stimulus
// stream and are checked every cycle against a pixel-level reference model.
module tb_ycbcr422_to_rgb565;

    localparam int HMAX = 8192;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs;
    logic       hr;
    logic       de;
    logic [7:0] y;
    logic [7:0] c;

    logic       a_vs, a_hr, a_de, b_vs, b_hr, b_de;
    logic [4:0] a_r, a_b, b_r, b_b;
    logic [5:0] a_g, b_g;

    ycbcr422_to_rgb565 #(.CB_FIRST(1), .COEF_FRAC(8)) u_dut_cb (
        .clk(clk), .rst(rst),
        .pre_frame_vsync(vs), .pre_frame_href(hr), .pre_frame_de(de),
        .img_y(y), .img_c(c),
        .post_frame_vsync(a_vs), .post_frame_href(a_hr), .post_frame_de(a_de),
        .img_red(a_r), .img_green(a_g), .img_blue(a_b)
    );

    ycbcr422_to_rgb565 #(.CB_FIRST(0), .COEF_FRAC(8)) u_dut_cr (
        .clk(clk), .rst(rst),
        .pre_frame_vsync(vs), .pre_frame_href(hr), .pre_frame_de(de),
        .img_y(y), .img_c(c),
        .post_frame_vsync(b_vs), .post_frame_href(b_hr), .post_frame_de(b_de),
        .img_red(b_r), .img_green(b_g), .img_blue(b_b)
    );

    always #5 clk = ~clk;

    logic [18:0] a_out, b_out;
    logic [15:0] a_rgb, b_rgb;
    assign a_rgb = {a_r, a_g, a_b};
    assign b_rgb = {b_r, b_g, b_b};
    assign a_out = {a_vs, a_hr, a_de, a_rgb};
    assign b_out = {b_vs, b_hr, b_de, b_rgb};

    bit         h_rst [HMAX];
    bit         h_vs  [HMAX];
    bit         h_hr  [HMAX];
    bit         h_de  [HMAX];
    logic [7:0] h_y   [HMAX];
    logic [7:0] h_c   [HMAX];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    function automatic int sat8(input int v);
        if (v < 0)   return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Colour conversion straight from the defining equations, integer arithmetic.
    function automatic logic [15:0] rgb_of(input int yv, input int cb, input int cr);
        int dcb, dcr, r, g, b;
        dcb = cb - 128;
        dcr = cr - 128;
`ifdef YCBCR2RGB_LIMITED_RANGE_EN
        r = (298 * (yv - 16) + 409 * dcr + 128) >>> 8;
        g = (298 * (yv - 16) - 100 * dcb - 208 * dcr + 128) >>> 8;
        b = (298 * (yv - 16) + 516 * dcb + 128) >>> 8;
`else
        r = (256 * yv + 359 * dcr + 128) >>> 8;
        g = (256 * yv - 88 * dcb - 183 * dcr + 128) >>> 8;
        b = (256 * yv + 454 * dcb + 128) >>> 8;
`endif
        r = sat8(r);
        g = sat8(g);
        b = sat8(b);
        return {5'(r >> 3), 6'(g >> 2), 5'(b >> 3)};
    endfunction

    // Expected {vsync, href, de, rgb565} for the input pixel of cycle n.
    function automatic logic [18:0] model(input int n, input bit cbf);
        int run, q, c1, c2, cb, cr;
        for (int k = n; k <= n + 5; k++)
            if (h_rst[k]) return '0;
        if (!h_de[n]) return {h_vs[n], h_hr[n], 1'b0, 16'd0};
        run = 0;
        q   = n - 1;
        while (q >= 0 && h_de[q] && !h_vs[q] && !h_rst[q]) begin
            run++;
            q--;
        end
        if (run % 2 == 0) begin
            c1 = int'(h_c[n]);
            c2 = h_de[n+1] ? int'(h_c[n+1]) : 128;
        end else begin
            c1 = int'(h_c[n-1]);
            c2 = int'(h_c[n]);
        end
        cb = cbf ? c1 : c2;
        cr = cbf ? c2 : c1;
        return {h_vs[n], h_hr[n], 1'b1, rgb_of(int'(h_y[n]), cb, cr)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit h, input bit d,
                        input logic [7:0] yy, input logic [7:0] cc);
        @(posedge clk);
        #1;
        rst = r; vs = v; hr = h; de = d; y = yy; c = cc;
        cyc++;
        h_rst[cyc] = r; h_vs[cyc] = v; h_hr[cyc] = h; h_de[cyc] = d;
        h_y[cyc] = yy;  h_c[cyc] = cc;
        @(negedge clk);
        if (cyc >= 6) begin
            chk("pipe_cb_first", 32'(a_out), 32'(model(cyc - 5, 1'b1)));
            chk("pipe_cr_first", 32'(b_out), 32'(model(cyc - 5, 1'b0)));
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic idle_to(input int target);
        while (cyc < target) idle(1);
    endtask

    task automatic pix(input logic [7:0] yy, input logic [7:0] cc);
        step(1'b0, 1'b0, 1'b1, 1'b1, yy, cc);
    endtask

    initial begin
        int n0, n1, len;
        logic [7:0] ry;

        for (int i = 0; i < HMAX; i++) begin
            h_rst[i] = 1'b0; h_vs[i] = 1'b0; h_hr[i] = 1'b0; h_de[i] = 1'b0;
            h_y[i] = '0; h_c[i] = '0;
        end
        h_rst[0] = 1'b1;
        rst = 1'b1; vs = 1'b0; hr = 1'b0; de = 1'b0; y = '0; c = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        chk("reset_out_cb", 32'(a_out), 32'd0);
        chk("reset_out_cr", 32'(b_out), 32'd0);
        idle(3);

`ifdef YCBCR2RGB_LIMITED_RANGE_EN
        chk("model_black", 32'(rgb_of(16, 128, 128)), 32'h0000);
        chk("model_white", 32'(rgb_of(235, 128, 128)), 32'hFFFF);

        n0 = cyc + 1;
        pix(8'd16, 8'd128); pix(8'd16, 8'd128);
        idle_to(n0 + 5);
        chk("lim_black_rgb", 32'(a_rgb), 32'h0000);
        chk("lim_black_de", 32'(a_de), 32'd1);

        idle(1);
        n0 = cyc + 1;
        pix(8'd235, 8'd128); pix(8'd235, 8'd128);
        idle_to(n0 + 5);
        chk("lim_white_rgb", 32'(a_rgb), 32'hFFFF);
`else
        chk("model_grey", 32'(rgb_of(128, 128, 128)), 32'h8410);
        chk("model_blue", 32'(rgb_of(50, 200, 128)), 32'h30D6);

        n0 = cyc + 1;
        pix(8'd128, 8'd128); pix(8'd128, 8'd128);
        idle_to(n0 + 4);
        chk("grey_not_early", 32'(a_de), 32'd0);
        idle_to(n0 + 5);
        chk("grey_de", 32'(a_de), 32'd1);
        chk("grey_rgb", 32'(a_rgb), 32'h8410);

        idle(1);
        n0 = cyc + 1;
        pix(8'd255, 8'd128); pix(8'd255, 8'd255);
        idle_to(n0 + 5);
        chk("sat_red_high", 32'(a_r), 32'd31);

        idle(1);
        n0 = cyc + 1;
        pix(8'd0, 8'd0); pix(8'd0, 8'd128);
        idle_to(n0 + 5);
        chk("sat_blue_low", 32'(a_b), 32'd0);
        chk("sat_green", 32'(a_g), 32'd11);
        chk("sat_red_low", 32'(a_r), 32'd0);

        idle(1);
        n0 = cyc + 1;
        pix(8'd50, 8'd200); pix(8'd50, 8'd128);
        idle_to(n0 + 5);
        chk("pair0_cb_first", 32'(a_rgb), 32'h30D6);
        chk("pair0_cr_first", 32'(b_rgb), 32'h9006);
        idle(1);
        chk("pair1_cb_first", 32'(a_rgb), 32'h30D6);
        chk("pair1_cr_first", 32'(b_rgb), 32'h9006);

        idle(1);
        n0 = cyc + 1;
        pix(8'd50, 8'd200); pix(8'd50, 8'd128); pix(8'd50, 8'd200);
        idle(1);
        n1 = cyc + 1;
        pix(8'd50, 8'd128); pix(8'd50, 8'd200);
        idle_to(n0 + 7);
        chk("odd_last_cb_first", 32'(a_rgb), 32'h30D6);
        chk("odd_last_cr_first", 32'(b_rgb), 32'h9006);
        idle_to(n1 + 5);
        chk("restart_cb_first", 32'(a_rgb), 32'h9006);
        chk("restart_cr_first", 32'(b_rgb), 32'h30D6);
`endif

        // Reset in the middle of an odd-length line.
        idle(2);
        n0 = cyc + 1;
        for (int i = 0; i < 5; i++) pix(8'd50, 8'd200);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'd50, 8'd200);
        chk("midreset_cb", 32'(a_out), 32'd0);
        chk("midreset_cr", 32'(b_out), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'd50, 8'd200);
        n1 = cyc + 1;
        pix(8'd50, 8'd128); pix(8'd50, 8'd200);
        idle_to(n1 + 5);
        chk("post_reset_de", 32'(a_de), 32'd1);
        chk("post_reset_phase", 32'(a_rgb), 32'(rgb_of(50, 128, 200)));

        // Randomized frames: variable line lengths, short gaps, vsync blocks, rare resets.
        for (int line = 0; line < 150; line++) begin
            if ($urandom_range(0, 14) == 0)
                for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 39) == 0)
                for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
            len = $urandom_range(1, 24);
            for (int p = 0; p < len; p++) begin
                case ($urandom_range(0, 7))
                    0:       ry = 8'd0;
                    1:       ry = 8'd255;
                    2:       ry = 8'($urandom_range(0, 20));
                    default: ry = 8'($urandom);
                endcase
                pix(ry, 8'($urandom));
            end
            for (int g = 0; g < $urandom_range(1, 4); g++)
                step(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
        end

        idle(8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
